// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-level round-robin scheduler sharing one UART transmitter
module uart_tx_sched #(
   parameter int         NUM_REQ  = 4,
   parameter bit         HDR_EN   = 1'b1,
   parameter logic [7:0] HDR_BASE = 8'hA0,
   localparam int        IDW      = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           uart_tx_data,
   output logic                 uart_tx_start,
   input  logic                 uart_tx_busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 grant_active,
   output logic                 pkt_done
);
   typedef enum logic [2:0] {ARB, HDR, ISSUE, WAIT_HI, WAIT_LO} state_t;
   state_t         state, state_n;
   logic [IDW-1:0] last_ptr, last_ptr_n, grant_id_n, pick, idx;
   logic           found, last_flag, last_flag_n, is_hdr, is_hdr_n;
   logic           grant_active_n, start_n, done_n;
   logic [7:0]     data_n, sel_data;
   assign sel_data = req_data[{grant_id, 3'b000} +: 8];
   // round-robin search: the lowest offset after last_ptr wins, so iterate downward and let later hits override
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDW'((int'(last_ptr) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
   // only the granted lane may see ready, and only while waiting for its next byte
   always_comb begin
      req_ready           = '0;
      req_ready[grant_id] = (state == ISSUE) & req_valid[grant_id];
   end
   // next-state and next-output logic; start and done are single-cycle unless re-asserted here
   always_comb begin
      state_n        = state;
      last_ptr_n     = last_ptr;
      grant_id_n     = grant_id;
      grant_active_n = grant_active;
      last_flag_n    = last_flag;
      is_hdr_n       = is_hdr;
      data_n         = uart_tx_data;
      start_n        = 1'b0;
      done_n         = 1'b0;
      case (state)
         ARB: if (found) begin
            grant_id_n     = pick;
            last_ptr_n     = pick;
            grant_active_n = 1'b1;
            state_n        = HDR_EN ? HDR : ISSUE;
         end
         HDR: begin
            data_n   = HDR_BASE | 8'(grant_id);
            start_n  = 1'b1;
            is_hdr_n = 1'b1;
            state_n  = WAIT_HI;
         end
         ISSUE: if (req_valid[grant_id]) begin
            data_n      = sel_data;
            start_n     = 1'b1;
            last_flag_n = req_last[grant_id];
            is_hdr_n    = 1'b0;
            state_n     = WAIT_HI;
         end
         WAIT_HI: state_n = uart_tx_busy ? WAIT_LO : WAIT_HI;
         WAIT_LO: if (!uart_tx_busy) begin
            done_n         = !is_hdr && last_flag;
            grant_active_n = !(!is_hdr && last_flag);
            state_n        = (!is_hdr && last_flag) ? ARB : ISSUE;
         end
         default: state_n = ARB;
      endcase
   end
   // state and registered outputs; reset abandons any packet in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ARB;
         last_ptr      <= IDW'(NUM_REQ - 1);
         grant_id      <= '0;
         grant_active  <= 1'b0;
         last_flag     <= 1'b0;
         is_hdr        <= 1'b0;
         uart_tx_data  <= '0;
         uart_tx_start <= 1'b0;
         pkt_done      <= 1'b0;
      end else begin
         state         <= state_n;
         last_ptr      <= last_ptr_n;
         grant_id      <= grant_id_n;
         grant_active  <= grant_active_n;
         last_flag     <= last_flag_n;
         is_hdr        <= is_hdr_n;
         uart_tx_data  <= data_n;
         uart_tx_start <= start_n;
         pkt_done      <= done_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for two scheduler instances (header on / header off)
module tb_uart_tx_sched;
   localparam int N = 4;
   localparam int FRAME = 40;
   logic clk = 1'b0;
   logic rst_n;
   logic track = 1'b1;
   logic [N-1:0] va = '0, la = '0, ra, vb = '0, lb = '0, rb;
   logic [N*8-1:0] da = '0, db = '0;
   logic [7:0] txa, txb;
   logic sa, sb, ba, bb, aa, ab, pa, pb;
   logic [1:0] ga, gb;
   int ca, cb;
   int checks = 0, errors = 0;
   logic [8:0] qa[N][$];
   logic [8:0] qb[N][$];
   logic [7:0] e[2][$];
   int gi[2][$];

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(N), .HDR_EN(1'b1), .HDR_BASE(8'hA0)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(va), .req_data(da), .req_last(la), .req_ready(ra),
      .uart_tx_data(txa), .uart_tx_start(sa), .uart_tx_busy(ba),
      .grant_id(ga), .grant_active(aa), .pkt_done(pa));
   uart_tx_sched #(.NUM_REQ(N), .HDR_EN(1'b0), .HDR_BASE(8'hA0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_data(db), .req_last(lb), .req_ready(rb),
      .uart_tx_data(txb), .uart_tx_start(sb), .uart_tx_busy(bb),
      .grant_id(gb), .grant_active(ab), .pkt_done(pb));

   // transmitter models: busy rises the cycle after start is sampled, stays up FRAME cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin ba <= 1'b0; ca <= 0; end
      else if (sa) begin ba <= 1'b1; ca <= FRAME; end
      else if (ca > 1) ca <= ca - 1;
      else begin ca <= 0; ba <= 1'b0; end
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin bb <= 1'b0; cb <= 0; end
      else if (sb) begin bb <= 1'b1; cb <= FRAME; end
      else if (cb > 1) cb <= cb - 1;
      else begin cb <= 0; bb <= 1'b0; end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(int u, int lane, logic [7:0] b, logic l);
      if (u == 0) qa[lane].push_back({l, b});
      else qb[lane].push_back({l, b});
   endtask

   task automatic mon(int u, logic s, logic [7:0] d, logic b, logic ps, logic [N-1:0] r,
                      logic p, logic [1:0] g, logic act);
      chk($sformatf("u%0d_ready_onehot", u), 32'($countones(r) <= 1), 1);
      if (s) begin
         chk($sformatf("u%0d_start_while_busy", u), b, 0);
         chk($sformatf("u%0d_start_twice", u), ps, 0);
         if (track) begin
            if (e[u].size() == 0) chk($sformatf("u%0d_unexpected_byte", u), d, 32'hFFFF);
            else chk($sformatf("u%0d_line_byte", u), d, e[u].pop_front());
         end
      end
      if (p) begin
         chk($sformatf("u%0d_done_active", u), act, 0);
         if (track) begin
            if (gi[u].size() == 0) chk($sformatf("u%0d_unexpected_done", u), g, 32'hFFFF);
            else chk($sformatf("u%0d_done_grant", u), g, gi[u].pop_front());
         end
      end
   endtask

   // requester model: lane queues drive valid/data/last; a byte pops once its handshake completes
   initial begin
      logic [N-1:0] ha, hb;
      forever begin
         @(negedge clk);
         ha = ra;
         hb = rb;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (ha[i] && qa[i].size() > 0) void'(qa[i].pop_front());
            if (hb[i] && qb[i].size() > 0) void'(qb[i].pop_front());
            va[i] = qa[i].size() > 0;
            vb[i] = qb[i].size() > 0;
            {la[i], da[i*8 +: 8]} = qa[i].size() > 0 ? qa[i][0] : 9'h0;
            {lb[i], db[i*8 +: 8]} = qb[i].size() > 0 ? qb[i][0] : 9'h0;
         end
      end
   end

   // monitor: checks every start against the scoreboard plus protocol rules
   initial begin
      logic psa, psb;
      psa = 1'b0;
      psb = 1'b0;
      forever begin
         @(negedge clk);
         mon(0, sa, txa, ba, psa, ra, pa, ga, aa);
         mon(1, sb, txb, bb, psb, rb, pb, gb, ab);
         psa = sa;
         psb = sb;
      end
   end

   task automatic flush_lanes();
      for (int i = 0; i < N; i++) begin
         qa[i].delete();
         qb[i].delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush_lanes();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while ((e[0].size() + e[1].size() + gi[0].size() + gi[1].size()) > 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 4000), 1);
      repeat (3) @(negedge clk);
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += qa[i].size() + qb[i].size();
      return s + 32'(aa) + 32'(ab);
   endfunction

   initial begin
      int n;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data_a", txa, 0);   chk("rst_start_a", sa, 0);  chk("rst_ready_a", ra, 0);
      chk("rst_grant_a", ga, 0);   chk("rst_active_a", aa, 0); chk("rst_done_a", pa, 0);
      chk("rst_data_b", txb, 0);   chk("rst_start_b", sb, 0);  chk("rst_ready_b", rb, 0);
      chk("rst_grant_b", gb, 0);   chk("rst_active_b", ab, 0); chk("rst_done_b", pb, 0);
      rst_n = 1'b1;

      // single header packet from requester 2
      push(0, 2, 8'h11, 1'b0); push(0, 2, 8'h22, 1'b1);
      e[0].push_back(8'hA2); e[0].push_back(8'h11); e[0].push_back(8'h22); gi[0].push_back(2);
      drain();
      chk("t1_active_idle", aa, 0);

      // full contention from reset: grant order 0,1,2,3,0,1,2,3
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) begin
            push(0, i, 8'(16 * (p + 1) + i), 1'b1);
            e[0].push_back(8'hA0 | 8'(i));
            e[0].push_back(8'(16 * (p + 1) + i));
            gi[0].push_back(i);
         end
      drain();

      // stall mid-packet on the header-less instance; requester 0 must wait
      do_reset();
      push(1, 1, 8'h55, 1'b0);
      e[1].push_back(8'h55);
      n = 0;
      while (!ab && n < 20) begin @(negedge clk); n++; end
      chk("t3_grant_timeout", 32'(n < 20), 1);
      push(1, 0, 8'h77, 1'b1);
      n = 0;
      while (qb[1].size() > 0 && n < 20) begin @(negedge clk); n++; end
      chk("t3_accept_timeout", 32'(n < 20), 1);
      repeat (50) begin
         @(negedge clk);
         chk("t3_ready0_stall", rb[0], 0);
      end
      chk("t3_grant_held", gb, 1);
      chk("t3_active_held", ab, 1);
      push(1, 1, 8'h66, 1'b1);
      e[1].push_back(8'h66); e[1].push_back(8'h77);
      gi[1].push_back(1); gi[1].push_back(0);
      n = 0;
      while (!pb && n < 200) begin
         @(negedge clk);
         n++;
         chk("t3_ready0_wait", rb[0], 0);
      end
      chk("t3_done_timeout", 32'(n < 200), 1);
      drain();

      // minimum latency and inter-byte gap
      do_reset();
      @(negedge clk);
      push(1, 2, 8'hAA, 1'b0); push(1, 2, 8'hBB, 1'b1);
      e[1].push_back(8'hAA); e[1].push_back(8'hBB); gi[1].push_back(2);
      @(negedge clk);
      chk("t4_c0_ready", rb, 0);
      @(negedge clk);
      chk("t4_c1_ready", rb, 4'b0100);
      chk("t4_c1_start", sb, 0);
      @(negedge clk);
      chk("t4_c2_start", sb, 1);
      n = 0;
      while (!bb && n < 10) begin @(negedge clk); n++; end
      while (bb && n < 100) begin @(negedge clk); n++; end
      chk("t4_busy_timeout", 32'(n < 100), 1);
      @(negedge clk);
      chk("t4_gap1_start", sb, 0);
      @(negedge clk);
      chk("t4_gap2_start", sb, 1);
      chk("t4_gap2_data", txb, 8'hBB);
      drain();

      // reset in the middle of the second payload byte of a 3-byte packet
      do_reset();
      push(0, 1, 8'hC1, 1'b0); push(0, 1, 8'hC2, 1'b0); push(0, 1, 8'hC3, 1'b1);
      e[0].push_back(8'hA1); e[0].push_back(8'hC1); e[0].push_back(8'hC2); e[0].push_back(8'hC3);
      gi[0].push_back(1);
      n = 0;
      while (!(sa && txa == 8'hC2) && n < 300) begin @(negedge clk); n++; end
      chk("t5_c2_timeout", 32'(n < 300), 1);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_data", txa, 0);  chk("t5_rst_start", sa, 0); chk("t5_rst_ready", ra, 0);
      chk("t5_rst_grant", ga, 0);  chk("t5_rst_active", aa, 0); chk("t5_rst_done", pa, 0);
      e[0].delete(); gi[0].delete();
      flush_lanes();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(0, 1, 8'hD1, 1'b1);
      push(0, 0, 8'hE0, 1'b0); push(0, 0, 8'hE1, 1'b1);
      e[0].push_back(8'hA0); e[0].push_back(8'hE0); e[0].push_back(8'hE1);
      e[0].push_back(8'hA1); e[0].push_back(8'hD1);
      gi[0].push_back(0); gi[0].push_back(1);
      drain();

      // random traffic on both instances, protocol rules only
      track = 1'b0;
      do_reset();
      repeat (300) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            push(0, int'($urandom_range(0, N - 1)), 8'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0)
            push(1, int'($urandom_range(0, N - 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < N; i++) begin
         push(0, i, 8'h5A, 1'b1);
         push(1, i, 8'hA5, 1'b1);
      end
      n = 0;
      while (pending() > 0 && n < 30000) begin @(negedge clk); n++; end
      chk("t6_drain_timeout", 32'(n < 30000), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
